// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int AW_DEFAULT = 19;
  localparam int DW_DEFAULT = 16;

  // Grant encoding: one bit selects the requester that owns the access.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin grant decision plus the last-grant register.
// The grant is combinational from the requests; the last grant only
// moves when the FSM actually commits to an access (grant_en).
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  input  logic grant_en,
  output logic any_req,
  output logic gnt
);

  logic last_gnt_reg;

  // Pick a winner: lone requester wins, a tie goes to the port not served last.
  always_comb begin
    any_req = a_req | b_req;
    gnt     = GNT_A;
    if (a_req && b_req) begin
      gnt = (last_gnt_reg == GNT_A) ? GNT_B : GNT_A;
    end else if (b_req) begin
      gnt = GNT_B;
    end
  end

  // Remember who was granted; reset to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_reg <= GNT_B;
    end else if (grant_en) begin
      last_gnt_reg <= gnt;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester asynchronous SRAM arbiter. Each access runs
// IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> RELEASE, with the request
// latched on entry to SETUP so requesters may change inputs freely.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int AW          = AW_DEFAULT,
  parameter int DW          = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  inout  tri   [DW-1:0] sram_data,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cs_n,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n,
  output logic          busy
);

  localparam logic [3:0] LAST_STROBE = 4'(WAIT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          gnt_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] a_rdata_reg, b_rdata_reg;

  logic          any_req;
  logic          gnt;
  logic          latch_en;
  logic          sample_en;
  logic          drive_en;

  sram_arb_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .b_req    (b_req),
    .grant_en (latch_en),
    .any_req  (any_req),
    .gnt      (gnt)
  );

  // Next-state and SRAM strobe decode; strobes are pure functions of state
  // so an asynchronous reset releases them immediately.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    sample_en  = 1'b0;
    drive_en   = 1'b0;
    sram_cs_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          latch_en   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        sram_cs_n  = 1'b0;
        drive_en   = we_reg;
        cnt_next   = 4'd0;
        state_next = STROBE;
      end
      STROBE: begin
        sram_cs_n = 1'b0;
        drive_en  = we_reg;
        sram_we_n = ~we_reg;
        sram_oe_n = we_reg;
        if (cnt_reg == LAST_STROBE) begin
          sample_en  = ~we_reg;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RELEASE: begin
        sram_cs_n  = 1'b0;
        drive_en   = we_reg;
        a_ack      = (gnt_reg == GNT_A);
        b_ack      = (gnt_reg == GNT_B);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and strobe-length counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the winning request at IDLE->SETUP; held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_reg   <= GNT_A;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (latch_en) begin
      gnt_reg   <= gnt;
      we_reg    <= (gnt == GNT_A) ? a_we    : b_we;
      addr_reg  <= (gnt == GNT_A) ? a_addr  : b_addr;
      wdata_reg <= (gnt == GNT_A) ? a_wdata : b_wdata;
    end
  end

  // Read data lands in the granted port's register on the last strobe cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else if (sample_en) begin
      if (gnt_reg == GNT_A) begin
        a_rdata_reg <= sram_data;
      end else begin
        b_rdata_reg <= sram_data;
      end
    end
  end

  assign sram_data = drive_en ? wdata_reg : {DW{1'bz}};
  assign sram_addr = addr_reg;
  assign sram_ub_n = sram_cs_n;
  assign sram_lb_n = sram_cs_n;
  assign a_rdata   = a_rdata_reg;
  assign b_rdata   = b_rdata_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM model.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [18:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  tri   [15:0] sram_data;
  logic [18:0] sram_addr;
  logic        sram_cs_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:255];

  sram_arbiter #(.WAIT_CYCLES(3), .AW(19), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives on output enable, stores on clock edges with WE low.
  assign sram_data = (!sram_cs_n && !sram_oe_n) ? mem[8'(sram_addr)] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n) mem[8'(sram_addr)] <= sram_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    step(); step();
    total++;
    if ({sram_cs_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      bad++; $display("FAIL reset_strobes: got %b want 11111",
        {sram_cs_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n});
    end
    total++;
    if ({busy, a_ack, b_ack} !== 3'b000) begin
      bad++; $display("FAIL reset_busy_ack: got %b want 000", {busy, a_ack, b_ack});
    end
    total++;
    if (a_rdata !== 16'h0 || b_rdata !== 16'h0 || sram_addr !== 19'h0) begin
      bad++; $display("FAIL reset_data: got a=%h b=%h addr=%h want 0", a_rdata, b_rdata, sram_addr);
    end
    rst = 1'b1;
    step();
    $display("reset: checked");
  endtask

  task automatic test_single_write();
    int we_low = 0, oe_low = 0, ack_at = 0, ack_cnt = 0, other = 0;
    a_we = 1; a_addr = 19'h00001; a_wdata = 16'hA55A; a_req = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        a_req = 0;
        total++;
        if (busy !== 1'b1 || sram_cs_n !== 1'b0 || sram_we_n !== 1'b1 ||
            sram_data !== 16'hA55A || sram_addr !== 19'h1) begin
          bad++; $display("FAIL wr_setup: got busy=%b cs=%b we=%b d=%h a=%h want 1 0 1 a55a 1",
            busy, sram_cs_n, sram_we_n, sram_data, sram_addr);
        end
      end
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (a_ack) begin ack_cnt++; ack_at = k; end
      if (b_ack) other++;
      if (k == 6) begin
        total++;
        if (busy !== 1'b0 || sram_data === 16'hA55A) begin
          bad++; $display("FAIL wr_release_bus: got busy=%b d=%h want 0 and bus released", busy, sram_data);
        end
      end
    end
    total++;
    if (we_low != 3 || oe_low != 0) begin
      bad++; $display("FAIL wr_strobes: got we_low=%0d oe_low=%0d want 3 0", we_low, oe_low);
    end
    total++;
    if (ack_at != 5 || ack_cnt != 1 || other != 0) begin
      bad++; $display("FAIL wr_ack: got at=%0d cnt=%0d b=%0d want 5 1 0", ack_at, ack_cnt, other);
    end
    $display("single_write: addr=1 data=a55a ack_at=%0d", ack_at);
  endtask

  task automatic test_read_back();
    int we_low = 0, oe_low = 0, ack_at = 0;
    logic [15:0] got = 16'h0;
    b_we = 0; b_addr = 19'h00001; b_req = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) b_req = 0;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (b_ack) begin ack_at = k; got = b_rdata; end
    end
    total++;
    if (got !== 16'hA55A) begin
      bad++; $display("FAIL rd_data: got %h want a55a", got);
    end
    total++;
    if (oe_low != 3 || we_low != 0 || ack_at != 5) begin
      bad++; $display("FAIL rd_strobes: got oe=%0d we=%0d ack_at=%0d want 3 0 5", oe_low, we_low, ack_at);
    end
    total++;
    if (a_rdata !== 16'h0) begin
      bad++; $display("FAIL rd_other_port: got a_rdata=%h want 0", a_rdata);
    end
    $display("read_back: b_rdata=%h ack_at=%0d", got, ack_at);
  endtask

  task automatic test_tie();
    int nev = 0, both = 0;
    int at [4];
    logic who [4];
    int exp_at [4] = '{5, 11, 17, 23};
    rst = 0;
    a_we = 1; a_addr = 19'h2; a_wdata = 16'h1111;
    b_we = 1; b_addr = 19'h3; b_wdata = 16'h2222;
    a_req = 1; b_req = 1;
    step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin at[i] = 0; who[i] = 1'b0; end
    for (int k = 1; k <= 40 && nev < 4; k++) begin
      step();
      if (a_ack && b_ack) both++;
      if (a_ack || b_ack) begin
        at[nev] = k; who[nev] = b_ack; nev++;
      end
    end
    a_req = 0; b_req = 0;
    total++;
    if (nev != 4) begin
      bad++; $display("FAIL tie_events: got %0d want 4", nev);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (who[i] !== 1'(i % 2) || at[i] != exp_at[i]) begin
        bad++; $display("FAIL tie_grant%0d: got port=%0d at=%0d want port=%0d at=%0d",
          i, who[i], at[i], i % 2, exp_at[i]);
      end
    end
    total++;
    if (both != 0) begin
      bad++; $display("FAIL tie_double_ack: got %0d want 0", both);
    end
    step();
    $display("tie: order %0d%0d%0d%0d", who[0], who[1], who[2], who[3]);
  endtask

  task automatic test_req_drop();
    int cnt = 0, ack_at = 0;
    logic [15:0] got = 16'h0;
    a_we = 0; a_addr = 19'h2; a_req = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) a_req = 0;
      if (a_ack) begin cnt++; ack_at = k; got = a_rdata; end
    end
    total++;
    if (cnt != 1 || ack_at != 5) begin
      bad++; $display("FAIL drop_ack: got cnt=%0d at=%0d want 1 5", cnt, ack_at);
    end
    total++;
    if (got !== 16'h1111) begin
      bad++; $display("FAIL drop_data: got %h want 1111", got);
    end
    $display("req_drop: a_rdata=%h", got);
  endtask

  task automatic test_addr_change();
    int wrong = 0, ack_at = 0;
    logic [15:0] got = 16'h0;
    a_we = 1; a_addr = 19'h4; a_wdata = 16'h3333; a_req = 1;
    step(); a_req = 0;
    step();
    a_addr = 19'h7FFFF; a_wdata = 16'hFFFF; a_we = 0;
    for (int k = 3; k <= 5; k++) begin
      step();
      if (sram_addr !== 19'h4 || sram_data !== 16'h3333) wrong++;
      if (a_ack) ack_at = k;
    end
    total++;
    if (wrong != 0 || ack_at != 5) begin
      bad++; $display("FAIL inflight_latch: got wrong=%0d ack_at=%0d want 0 5", wrong, ack_at);
    end
    total++;
    if (a_rdata !== 16'h1111) begin
      bad++; $display("FAIL write_keeps_rdata: got %h want 1111", a_rdata);
    end
    step();
    b_we = 0; b_addr = 19'h4; b_req = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) b_req = 0;
      if (b_ack) got = b_rdata;
    end
    total++;
    if (got !== 16'h3333) begin
      bad++; $display("FAIL inflight_readback: got %h want 3333", got);
    end
    $display("addr_change: sram_addr held 4, readback=%h", got);
  endtask

  task automatic test_reset_mid();
    int acks = 0, ack_at = 0;
    logic [15:0] got = 16'h0;
    a_we = 1; a_addr = 19'h5; a_wdata = 16'h4444; a_req = 1;
    step(); a_req = 0;
    step();
    total++;
    if (sram_we_n !== 1'b0) begin
      bad++; $display("FAIL rst_mid_pre: got we_n=%b want 0", sram_we_n);
    end
    #2 rst = 0;
    #1;
    total++;
    if (sram_we_n !== 1'b1 || sram_cs_n !== 1'b1 || busy !== 1'b0 || sram_data === 16'h4444) begin
      bad++; $display("FAIL rst_mid_async: got we=%b cs=%b busy=%b d=%h want 1 1 0 released",
        sram_we_n, sram_cs_n, busy, sram_data);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (a_ack || b_ack) acks++;
    end
    rst = 1;
    step();
    if (a_ack || b_ack) acks++;
    total++;
    if (acks != 0 || busy !== 1'b0 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      bad++; $display("FAIL rst_mid_after: got acks=%0d busy=%b a=%h b=%h want 0 0 0 0",
        acks, busy, a_rdata, b_rdata);
    end
    a_we = 0; a_addr = 19'h1; a_req = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) a_req = 0;
      if (a_ack) begin ack_at = k; got = a_rdata; end
    end
    total++;
    if (ack_at != 5 || got !== 16'hA55A) begin
      bad++; $display("FAIL rst_mid_restart: got at=%0d d=%h want 5 a55a", ack_at, got);
    end
    $display("reset_mid: restart read=%h", got);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_tie();
    test_req_drop();
    test_addr_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, is the number of strobe-active cycles per SRAM access (legal 1..15).
REQ-002 Parameter AW, default 19, is the SRAM address width.
REQ-003 Parameter DW, default 16, is the SRAM data width.
REQ-004 Port clk, input, 1, is the single system clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, is the asynchronous, active-low reset.
REQ-006 Ports a_req / b_req, input, 1 each, are the access requests from requester A (UART loader) and requester B (reader/CPU).
REQ-007 Ports a_we / b_we, input, 1 each, select write (1) or read (0).
REQ-008 Ports a_addr / b_addr, input, AW each, are the word addresses.
REQ-009 Ports a_wdata / b_wdata, input, DW each, are the write data.
REQ-010 Ports a_ack / b_ack, output, 1 each, are one-cycle completion pulses.
REQ-011 Ports a_rdata / b_rdata, output, DW each, are the read data, valid from the ack cycle until the next read completes on that port.
REQ-012 Port sram_data, inout, DW, is the SRAM data bus.
REQ-013 Port sram_addr, output, AW, is the SRAM address.
REQ-014 Ports sram_cs_n, sram_we_n, sram_oe_n, sram_ub_n and sram_lb_n, output, 1 each, are the active-low SRAM controls.
REQ-015 Port busy, output, 1, is high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM shall have the states IDLE, SETUP, STROBE and RELEASE; IDLE->SETUP on any request, SETUP->STROBE after 1 cycle, STROBE->RELEASE after WAIT_CYCLES cycles, RELEASE->IDLE after 1 cycle.
REQ-017 Grant shall be decided in IDLE only: a single request is granted directly; simultaneous requests go round-robin against the last granted port.
REQ-018 Grant, we, addr and wdata shall be latched at the IDLE->SETUP edge; later changes on requester inputs shall not affect the access in flight.
REQ-019 In SETUP, STROBE and RELEASE: sram_cs_n=0, ub_n=0, lb_n=0, and sram_addr holds the latched address.
REQ-020 sram_we_n (write) or sram_oe_n (read) shall be 0 only in STROBE.
REQ-021 On writes, sram_data shall be driven from SETUP through RELEASE (hold margin); otherwise it is high-Z.
REQ-022 On reads, sram_data shall be sampled on the last STROBE cycle into the granted port's rdata.
REQ-023 The granted port's ack shall pulse high for exactly the RELEASE cycle; the other ack stays 0.
REQ-024 Latency from request sampled in IDLE to ack shall be WAIT_CYCLES+2 cycles; back-to-back accesses have period WAIT_CYCLES+3.
REQ-025 A request deasserted mid-access shall not abort the access; the access completes and ack still pulses.
REQ-026 A request still high in the IDLE cycle after its ack shall be treated as a new access.
REQ-027 A port that is not granted shall wait with no ack; round robin guarantees it is granted next.
REQ-028 The address is used as latched, with no increment or wrap; the requester owns address sequencing.

Reset
REQ-029 While rst=0: state=IDLE, all sram_*_n=1, sram_addr=0, sram_data high-Z, acks=0, rdata=0, busy=0, and last-grant=B so that A wins the first tie.
REQ-030 Reset asserted mid-access shall abort immediately with no ack; after release the FSM restarts from IDLE.

Structure
REQ-031 Package sram_arb_pkg shall hold the state enum, the AW/DW defaults and the grant encoding (GNT_A=0, GNT_B=1).
REQ-032 Sub-module sram_arb_rr shall implement the 2-way round-robin grant and last-grant register; the FSM and bus logic stay in sram_arbiter.

Verification
REQ-033 Single write: A writes addr 0x00001, data 0xA55A, WAIT_CYCLES=3 -> we_n low 3 cycles, a_ack 5 cycles after request, bus high-Z after RELEASE.
REQ-034 Read-back: B reads 0x00001 from an SRAM model -> b_rdata=0xA55A on b_ack, oe_n low 3 cycles, we_n never low.
REQ-035 Tie: a_req and b_req both high from reset -> A served first, then B; both held high -> grants alternate A,B,A,B.
REQ-036 Request drop: a_req pulsed for 1 cycle -> full access completes and a_ack pulses once.
REQ-037 Reset mid-STROBE: rst low during a write -> strobes return to 1 asynchronously, no ack, IDLE after release.
REQ-038 Input change in flight: a_addr changed during STROBE -> sram_addr keeps the latched value.
